// File: rtl/simple_alu_pkg.sv
// Shared constants for the registered add/subtract stage.
package simple_alu_pkg;

  localparam int   ALU_WIDTH_DEFAULT = 8;
  localparam logic OP_ADD            = 1'b0;
  localparam logic OP_SUB            = 1'b1;

endpackage

// File: rtl/simple_alu_if.sv
// Operand/result bundle for simple_alu; master drives operands, slave returns registered flags.
interface simple_alu_if
  import simple_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) ();

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             csub;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output opa, opb, csub,
    input  result, cout, ovf, zero
  );

  modport slave (
    input  opa, opb, csub,
    output result, cout, ovf, zero
  );

endinterface

// File: rtl/simple_alu_adder.sv
// Carry-in/carry-out adder that also reports the signed-overflow term of a + b.
module alu_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH:0] sum_ext;

  assign sum_ext     = {1'b0, b} + {1'b0, a} + {{WIDTH{1'b0}}, cin};
  assign sum         = sum_ext[WIDTH-1:0];
  assign cout        = sum_ext[WIDTH];
  // Overflow only when both addends share a sign and the sum's sign differs.
  assign ovf         = (b[WIDTH-1] == a[WIDTH-1]) && (sum[WIDTH-1] != b[WIDTH-1]);

endmodule

// File: rtl/simple_alu.sv
// Registered add/subtract: csub inverts opa and supplies the carry-in, giving opb - opa.
module simple_alu
  import simple_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  simple_alu_if.slave bus
);

  logic [WIDTH-1:0] opa_mux;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             ovf_n;
  logic             zero_n;

  assign opa_mux = (bus.csub == OP_SUB) ? ~bus.opa : bus.opa;

  alu_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (opa_mux),
    .b    (bus.opb),
    .cin  (bus.csub),
    .sum  (sum),
    .cout (carry),
    .ovf  (ovf_n)
  );

  assign zero_n = (sum == '0);

  // zero resets high so the flag agrees with the cleared result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.result <= '0;
      bus.cout   <= 1'b0;
      bus.ovf    <= 1'b0;
      bus.zero   <= 1'b1;
    end else begin
      bus.result <= sum;
      bus.cout   <= carry;
      bus.ovf    <= ovf_n;
      bus.zero   <= zero_n;
    end
  end

endmodule

// File: tb/tb_simple_alu.sv
// Directed and random-operand bench for simple_alu at WIDTH=8.
module tb_simple_alu;
  import simple_alu_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  simple_alu_if #(.WIDTH(W)) bus ();

  simple_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference from arithmetic definitions: {result, cout, ovf, zero}.
  function automatic logic [W+2:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub);
    int          sa, sb, sres;
    logic [W-1:0] r;
    logic        c, v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      r    = b - a;
      c    = (b >= a);
      sres = sb - sa;
    end else begin
      r    = a + b;
      c    = ((int'(a) + int'(b)) > 255);
      sres = sb + sa;
    end
    v = (sres > 127) || (sres < -128);
    return {r, c, v, (r == 8'h00)};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] er, input logic ec,
                       input logic ev, input logic ez);
    checks++;
    assert (bus.result === er) else begin
      errors++;
      $error("FAIL %s result got %h expected %h", tag, bus.result, er);
    end
    checks++;
    assert (bus.cout === ec) else begin
      errors++;
      $error("FAIL %s cout got %b expected %b", tag, bus.cout, ec);
    end
    checks++;
    assert (bus.ovf === ev) else begin
      errors++;
      $error("FAIL %s ovf got %b expected %b", tag, bus.ovf, ev);
    end
    checks++;
    assert (bus.zero === ez) else begin
      errors++;
      $error("FAIL %s zero got %b expected %b", tag, bus.zero, ez);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    bus.opa  = a;
    bus.opb  = b;
    bus.csub = sub;
  endtask

  // Drive on a falling edge, capture on the rising edge, sample on the next falling edge.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    drive(a, b, sub);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [W+2:0] exp_v;
    logic [W-1:0] ra, rb;
    logic         rs;

    checks = 0;
    errors = 0;
    rst    = 1'b0;
    drive(8'h00, 8'h00, OP_ADD);

    // Async reset mid-cycle, observed before any clock edge.
    #2 rst = 1'b1;
    #1 check("reset_async", 8'h00, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(8'h03, 8'h05, OP_ADD);
    @(posedge clk);
    @(negedge clk);
    check("reset_hold", 8'h00, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;

    op(8'h03, 8'h05, OP_ADD);
    check("add_3_5", 8'h08, 1'b0, 1'b0, 1'b0);

    op(8'hff, 8'h01, OP_ADD);
    check("add_wrap", 8'h00, 1'b1, 1'b0, 1'b1);

    op(8'h03, 8'h0a, OP_SUB);
    check("sub_a_3", 8'h07, 1'b1, 1'b0, 1'b0);

    op(8'h01, 8'h00, OP_SUB);
    check("sub_borrow", 8'hff, 1'b0, 1'b0, 1'b0);

    op(8'h01, 8'h7f, OP_ADD);
    check("add_ovf", 8'h80, 1'b0, 1'b1, 1'b0);

    op(8'h01, 8'h80, OP_SUB);
    check("sub_ovf", 8'h7f, 1'b1, 1'b1, 1'b0);

    op(8'h05, 8'h05, OP_SUB);
    check("sub_equal", 8'h00, 1'b1, 1'b0, 1'b1);

    op(8'h80, 8'h80, OP_ADD);
    check("add_neg_ovf", 8'h00, 1'b1, 1'b1, 1'b1);

    // Back-to-back stream with csub toggling every cycle.
    exp_v = '0;
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'(i % 2);
      drive(ra, rb, rs);
      @(posedge clk);
      @(negedge clk);
      if (i > 0) begin
        // Outputs must still follow each new cycle with no bubble.
      end
      exp_v = ref_op(ra, rb, rs);
      check($sformatf("stream_%0d", i), exp_v[W+2:3], exp_v[2], exp_v[1], exp_v[0]);
    end

    // Reset pulse between two operations discards the captured result.
    op(8'h10, 8'h20, OP_ADD);
    check("pre_reset_op", 8'h30, 1'b0, 1'b0, 1'b0);
    drive(8'h11, 8'h22, OP_ADD);
    #2 rst = 1'b1;
    #1 check("midstream_reset", 8'h00, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("midstream_hold", 8'h00, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    op(8'h05, 8'h06, OP_ADD);
    check("post_reset_op", 8'h0b, 1'b0, 1'b0, 1'b0);
    op(8'h06, 8'h05, OP_SUB);
    check("post_reset_sub", 8'hff, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
